// File: rtl/rv32i_mem_loader_pkg.sv
// Shared opcodes, FSM encoding and address helper for the rv32i program/data loader.
package rv32i_mem_loader_pkg;

   localparam logic [3:0] LDR_OP_LOAD  = 4'hA;
   localparam logic [7:0] LDR_OP_RUN   = 8'hC0;
   localparam logic [7:0] LDR_OP_HALT  = 8'hC1;
   localparam logic [7:0] LDR_OP_CLEAR = 8'hC2;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADR0,
      ST_ADR1,
      ST_CNT0,
      ST_CNT1,
      ST_DATA,
      ST_WR,
      ST_CSUM
   } ldr_state_e;

   // Word index wraps at 16 bits before conversion to a byte address.
   function automatic logic [17:0] word_byte_addr(input logic [15:0] base, input logic [15:0] idx);
      logic [15:0] widx;
      widx = base + idx;
      return {widx, 2'b00};
   endfunction

endpackage

// File: rtl/rv32i_mem_loader_if.sv
// Byte-stream input and BRAM write bus of the loader; master = loader side.
interface rv32i_mem_loader_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int NUM_TARGETS = 2
);
   logic [7:0]              s_dat;
   logic                    s_valid;
   logic                    s_ready;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_dat;
   logic [NUM_TARGETS-1:0]  w_enb;
   logic [DATA_WIDTH/8-1:0] w_byte_enb;

   modport master (
      input  s_dat, s_valid,
      output s_ready, w_addr, w_dat, w_enb, w_byte_enb
   );

   modport slave (
      output s_dat, s_valid,
      input  s_ready, w_addr, w_dat, w_enb, w_byte_enb
   );
endinterface

// File: rtl/rv32i_mem_loader_word_assembler.sv
// Packs little-endian stream bytes into words and keeps the running XOR of all data bytes.
module loader_word_assembler #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  byte_vld,
   input  logic [7:0]            byte_dat,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid,
   output logic [7:0]            csum
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [7:0]            csum_q, csum_d;

   always_comb begin
      sh_d   = sh_q;
      idx_d  = idx_q;
      csum_d = csum_q;
      if (clr) begin
         sh_d   = '0;
         idx_d  = '0;
         csum_d = '0;
      end else if (byte_vld) begin
         sh_d   = {byte_dat, sh_q[DATA_WIDTH-1:8]};
         csum_d = csum_q ^ byte_dat;
         idx_d  = (idx_q == IW'(NB - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         idx_q  <= '0;
         csum_q <= '0;
      end else begin
         sh_q   <= sh_d;
         idx_q  <= idx_d;
         csum_q <= csum_d;
      end
   end

   // The completed word includes the byte arriving this cycle.
   assign word       = {byte_dat, sh_q[DATA_WIDTH-1:8]};
   assign word_valid = byte_vld & (idx_q == IW'(NB - 1));
   assign csum       = csum_q;

endmodule

// File: rtl/rv32i_mem_loader.sv
// Framed byte-stream loader for the rv32i_sc BRAMs; also owns core stall/reset sequencing.
//  state | meaning
//  CMD   | waiting for an opcode byte
//  ADR0  | base word address, low byte
//  ADR1  | base word address, high byte
//  CNT0  | word count, low byte
//  CNT1  | word count, high byte
//  DATA  | collecting bytes of the current word
//  WR    | one-cycle BRAM write, stream stalled
//  CSUM  | checksum byte, then back to CMD
module rv32i_mem_loader
   import rv32i_mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int NUM_TARGETS = 2
) (
   input  logic               clk,
   input  logic               rst,
   rv32i_mem_loader_if.master bus,
   output logic               load_busy,
   output logic               load_done,
   output logic               cpu_stall,
   output logic               cpu_rst,
   output logic               err_cmd,
   output logic               err_checksum
);
   localparam int         NB  = DATA_WIDTH / 8;
   localparam logic [4:0] NTG = 5'(NUM_TARGETS);

   ldr_state_e              state_q, state_d;
   logic [15:0]             base_q, base_d, cnt_q, cnt_d, idx_q, idx_d;
   logic [3:0]              tgt_q, tgt_d;
   logic                    s_ready_q, s_ready_d;
   logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
   logic [DATA_WIDTH-1:0]   w_dat_q, w_dat_d;
   logic [NUM_TARGETS-1:0]  w_enb_q, w_enb_d;
   logic [NB-1:0]           w_byte_enb_q, w_byte_enb_d;
   logic                    load_busy_q, load_busy_d, load_done_q, load_done_d;
   logic                    cpu_stall_q, cpu_stall_d, cpu_rst_q, cpu_rst_d;
   logic                    err_cmd_q, err_cmd_d, err_cs_q, err_cs_d;
   logic                    xfer, asm_clr, asm_vld, asm_word_valid;
   logic [DATA_WIDTH-1:0]   asm_word;
   logic [7:0]              asm_csum;

   assign xfer = bus.s_valid & s_ready_q;

   loader_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (asm_clr),
      .byte_vld   (asm_vld),
      .byte_dat   (bus.s_dat),
      .word       (asm_word),
      .word_valid (asm_word_valid),
      .csum       (asm_csum)
   );

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      tgt_d       = tgt_q;
      w_addr_d    = w_addr_q;
      w_dat_d     = w_dat_q;
      w_enb_d     = '0;
      load_done_d = 1'b0;
      cpu_stall_d = cpu_stall_q;
      cpu_rst_d   = cpu_rst_q;
      err_cmd_d   = err_cmd_q;
      err_cs_d    = err_cs_q;
      asm_clr     = 1'b0;
      asm_vld     = xfer && (state_q == ST_DATA);
      case (state_q)
         ST_CMD: if (xfer) begin
            if (bus.s_dat[7:4] == LDR_OP_LOAD) begin
               if ({1'b0, bus.s_dat[3:0]} < NTG) begin
                  tgt_d       = bus.s_dat[3:0];
                  idx_d       = '0;
                  asm_clr     = 1'b1;
                  cpu_stall_d = 1'b1;
                  cpu_rst_d   = 1'b1;
                  state_d     = ST_ADR0;
               end else begin
                  err_cmd_d = 1'b1;
               end
            end else begin
               case (bus.s_dat)
                  LDR_OP_RUN: begin
                     cpu_stall_d = 1'b0;
                     cpu_rst_d   = 1'b0;
                  end
                  LDR_OP_HALT:  cpu_stall_d = 1'b1;
                  LDR_OP_CLEAR: begin
                     err_cmd_d = 1'b0;
                     err_cs_d  = 1'b0;
                  end
                  default:      err_cmd_d = 1'b1;
               endcase
            end
         end
         ST_ADR0: if (xfer) begin
            base_d[7:0] = bus.s_dat;
            state_d     = ST_ADR1;
         end
         ST_ADR1: if (xfer) begin
            base_d[15:8] = bus.s_dat;
            state_d      = ST_CNT0;
         end
         ST_CNT0: if (xfer) begin
            cnt_d[7:0] = bus.s_dat;
            state_d    = ST_CNT1;
         end
         ST_CNT1: if (xfer) begin
            cnt_d[15:8] = bus.s_dat;
            state_d     = ({bus.s_dat, cnt_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
         end
         ST_DATA: if (asm_word_valid) begin
            w_enb_d  = NUM_TARGETS'(1) << tgt_q;
            w_addr_d = ADDR_WIDTH'(word_byte_addr(base_q, idx_q));
            w_dat_d  = asm_word;
            state_d  = ST_WR;
         end
         ST_WR: begin
            idx_d   = idx_q + 16'd1;
            state_d = ((idx_q + 16'd1) == cnt_q) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: if (xfer) begin
            if (bus.s_dat != asm_csum) err_cs_d = 1'b1;
            load_done_d = 1'b1;
            state_d     = ST_CMD;
         end
         default: state_d = ST_CMD;
      endcase
      s_ready_d    = (state_d != ST_WR);
      load_busy_d  = (state_d != ST_CMD);
      w_byte_enb_d = (w_enb_d != '0) ? '1 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CMD;
         base_q       <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         tgt_q        <= '0;
         s_ready_q    <= 1'b0;
         w_addr_q     <= '0;
         w_dat_q      <= '0;
         w_enb_q      <= '0;
         w_byte_enb_q <= '0;
         load_busy_q  <= 1'b0;
         load_done_q  <= 1'b0;
         cpu_stall_q  <= 1'b1;
         cpu_rst_q    <= 1'b1;
         err_cmd_q    <= 1'b0;
         err_cs_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         tgt_q        <= tgt_d;
         s_ready_q    <= s_ready_d;
         w_addr_q     <= w_addr_d;
         w_dat_q      <= w_dat_d;
         w_enb_q      <= w_enb_d;
         w_byte_enb_q <= w_byte_enb_d;
         load_busy_q  <= load_busy_d;
         load_done_q  <= load_done_d;
         cpu_stall_q  <= cpu_stall_d;
         cpu_rst_q    <= cpu_rst_d;
         err_cmd_q    <= err_cmd_d;
         err_cs_q     <= err_cs_d;
      end
   end

   assign bus.s_ready    = s_ready_q;
   assign bus.w_addr     = w_addr_q;
   assign bus.w_dat      = w_dat_q;
   assign bus.w_enb      = w_enb_q;
   assign bus.w_byte_enb = w_byte_enb_q;
   assign load_busy      = load_busy_q;
   assign load_done      = load_done_q;
   assign cpu_stall      = cpu_stall_q;
   assign cpu_rst        = cpu_rst_q;
   assign err_cmd        = err_cmd_q;
   assign err_checksum   = err_cs_q;

endmodule

// File: tb/tb_rv32i_mem_loader.sv
// Scoreboard bench for rv32i_mem_loader: frames are built from a reference model, writes checked by a monitor.
module tb_rv32i_mem_loader;
   import rv32i_mem_loader_pkg::*;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_busy, load_done, cpu_stall, cpu_rst, err_cmd, err_checksum;

   always #5 clk = ~clk;

   rv32i_mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT)) bus ();

   rv32i_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .load_busy    (load_busy),
      .load_done    (load_done),
      .cpu_stall    (cpu_stall),
      .cpu_rst      (cpu_rst),
      .err_cmd      (err_cmd),
      .err_checksum (err_checksum)
   );

   typedef struct packed {
      logic [NT-1:0] enb;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
   } wr_t;

   wr_t wr_q[$];
   bit  done_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  rst_age = 0;
   bit  gaps = 1'b0;
   bit  m_stall, m_crst, m_ecmd, m_ecs;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(posedge clk) rst_age <= rst ? 0 : rst_age + 1;

   // Monitor: every write and every load_done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && rst_age >= 1) begin
         check("s_ready_low_only_in_write", bus.s_ready, (bus.w_enb == '0));
         if (bus.w_enb != '0) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got enb %0h addr %0h dat %0h expected none", bus.w_enb, bus.w_addr, bus.w_dat);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               check("w_enb", bus.w_enb, e.enb);
               check("w_addr", bus.w_addr, e.addr);
               check("w_dat", bus.w_dat, e.dat);
               check("w_byte_enb", bus.w_byte_enb, 4'hF);
            end
         end else begin
            check("w_byte_enb_idle", bus.w_byte_enb, 4'h0);
         end
         if (load_done) begin
            check("load_busy_at_done", load_busy, 1'b0);
            if (done_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_load_done: got pulse expected none");
            end else begin
               bit e;
               e = done_q.pop_front();
               check("err_checksum_at_done", err_checksum, e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      if (gaps) begin
         int n;
         n = $urandom_range(0, 3);
         repeat (n) begin
            bus.s_dat = 8'($urandom);
            @(posedge clk);
            #1;
         end
      end
      bus.s_dat   = b;
      bus.s_valid = 1'b1;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (bus.s_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         t++;
         if (t > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: got s_ready stuck low expected accept of %0h", b);
            break;
         end
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic check_flags(string tag);
      check({tag, "_cpu_stall"}, cpu_stall, m_stall);
      check({tag, "_cpu_rst"}, cpu_rst, m_crst);
      check({tag, "_err_cmd"}, err_cmd, m_ecmd);
      check({tag, "_err_checksum"}, err_checksum, m_ecs);
   endtask

   task automatic send_cmd(input logic [7:0] op, input string tag);
      send_byte(op);
      if (op == LDR_OP_RUN) begin
         m_stall = 0;
         m_crst  = 0;
      end else if (op == LDR_OP_HALT) begin
         m_stall = 1;
      end else if (op == LDR_OP_CLEAR) begin
         m_ecmd = 0;
         m_ecs  = 0;
      end else begin
         m_ecmd = 1;
      end
      check_flags(tag);
   endtask

   task automatic send_load(input int t, input logic [15:0] base, input logic [31:0] words[$], input bit bad);
      logic [7:0] cs;
      int         n;
      cs = 8'h00;
      n  = words.size();
      send_byte({LDR_OP_LOAD, 4'(t)});
      m_stall = 1;
      m_crst  = 1;
      check("load_busy_after_opcode", load_busy, 1'b1);
      check_flags("load_accept");
      send_byte(base[7:0]);
      send_byte(base[15:8]);
      send_byte(8'(n));
      send_byte(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         int wa;
         wa = (((int'(base) + i) % 65536) * 4) % (1 << AW);
         wr_q.push_back('{enb: NT'(1 << t), addr: AW'(wa), dat: words[i]});
         for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b  = 8'(words[i] >> (8 * k));
            cs = cs ^ b;
            send_byte(b);
         end
      end
      if (bad) m_ecs = 1;
      done_q.push_back(m_ecs);
      send_byte(bad ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_ready", bus.s_ready, 1'b0);
      check("rst_w_enb", bus.w_enb, '0);
      check("rst_w_addr", bus.w_addr, '0);
      check("rst_w_dat", bus.w_dat, '0);
      check("rst_w_byte_enb", bus.w_byte_enb, '0);
      check("rst_load_busy", load_busy, 1'b0);
      check("rst_load_done", load_done, 1'b0);
      m_stall = 1;
      m_crst  = 1;
      m_ecmd  = 0;
      m_ecs   = 0;
      check_flags("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("release_s_ready", bus.s_ready, 1'b1);
   endtask

   initial begin
      logic [31:0] w[$];
      int          guard;
      bus.s_dat   = 8'h00;
      bus.s_valid = 1'b0;
      reset_dut();

      // Directed two-word program into I-BRAM, then RUN.
      w = '{32'h0050_0293, 32'h00A0_0313};
      send_load(0, 16'h0000, w, 1'b0);
      send_cmd(LDR_OP_RUN, "run");

      // Same frame with a corrupted checksum, then CLEAR and illegal opcodes.
      send_load(0, 16'h0000, w, 1'b1);
      @(posedge clk);
      #1;
      check_flags("after_bad_csum");
      send_cmd(LDR_OP_CLEAR, "clear");
      send_cmd(8'h55, "bad_op_55");
      send_cmd(LDR_OP_CLEAR, "clear2");
      send_cmd(8'hA7, "bad_target_a7");
      send_cmd(LDR_OP_CLEAR, "clear3");

      // Address wrap into target 1, plain and with gaps.
      w = '{32'h1122_3344, 32'hDEAD_BEEF};
      send_load(1, 16'h03FF, w, 1'b0);
      gaps = 1'b1;
      send_load(1, 16'h03FF, w, 1'b0);
      gaps = 1'b0;

      // Run/halt sequencing and a zero-length load while running.
      send_cmd(LDR_OP_RUN, "seq_run");
      send_cmd(LDR_OP_HALT, "seq_halt");
      send_cmd(LDR_OP_RUN, "seq_resume");
      w = {};
      send_load(1, 16'h0123, w, 1'b0);

      // Reset mid-frame after three data bytes.
      send_byte(8'hA0);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      reset_dut();
      w = '{32'hCAFE_F00D};
      send_load(0, 16'h0010, w, 1'b0);

      // Randomised frames and commands.
      for (int f = 0; f < 14; f++) begin
         int n;
         gaps = ($urandom_range(0, 1) == 1);
         n = $urandom_range(0, 4);
         w = {};
         for (int i = 0; i < n; i++) w.push_back($urandom);
         send_load($urandom_range(0, NT - 1), 16'($urandom), w, ($urandom_range(0, 3) == 0));
         case ($urandom_range(0, 3))
            0: send_cmd(LDR_OP_RUN, "rnd_run");
            1: send_cmd(LDR_OP_HALT, "rnd_halt");
            2: send_cmd(LDR_OP_CLEAR, "rnd_clear");
            default: ;
         endcase
      end
      gaps = 1'b0;

      guard = 0;
      while ((wr_q.size() != 0 || done_q.size() != 0) && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check("pending_writes", wr_q.size(), 0);
      check("pending_done", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
